// File: rtl/mem_stage.sv
// Memory stage: picks the highest ready load/store slot, runs one bus transaction, then stamps the slot.
// Latency: store 3 cycles, load 4 cycles minimum; mem_req holds until mem_gnt, WAIT holds until mem_rvalid.
module mem_stage #(
  parameter int NSLOT  = 8,
  parameter int INSN_W = 88,
  parameter int AW     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3*NSLOT-1:0]      reg_start_flat,
  input  logic [INSN_W*NSLOT-1:0] reg_out_flat,
  output logic [3*NSLOT-1:0]      stamp_flat,
  output logic [NSLOT-1:0]        stamp_in,
  output logic [4:0]              reg_search_out10,
  input  logic [31:0]             reg_out10,
  output logic [4:0]              reg_search_out11,
  input  logic [31:0]             reg_out11,
  output logic [4:0]              reg_search_in10,
  output logic [31:0]             reg_in10,
  output logic                    reg_in10_start,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [AW-1:0]           mem_addr,
  output logic [3:0]              mem_be,
  output logic [31:0]             mem_wdata,
  input  logic                    mem_gnt,
  input  logic                    mem_rvalid,
  input  logic [31:0]             mem_rdata,
  output logic                    busy,
  output logic                    err
);
  localparam int IDXW = (NSLOT > 1) ? $clog2(NSLOT) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [5:0] OP_LW = 6'b001010;
  localparam logic [5:0] OP_SW = 6'b001011;
  localparam logic [5:0] OP_LB = 6'b001100;
  localparam logic [5:0] OP_SB = 6'b001101;

  logic [1:0]        state_q, state_d;
  logic [IDXW-1:0]   idx_q, sel;
  logic              found;
  logic [INSN_W-1:0] sel_slot;
  logic [5:0]        sel_op, op_i;
  logic [15:0]       sel_imm;
  logic              sel_load, sel_byte, sel_mis;
  logic [AW-1:0]     addr_calc;
  logic [3:0]        be_calc;
  logic [31:0]       wdata_calc;
  logic              load_q, byte_q, mis_q;
  logic [4:0]        rd_q;
  logic [2:0]        st_q;
  logic [AW-1:0]     addr_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q, result_q;
  logic [7:0]        rbyte;
  logic              unused_bits;

  // Highest-indexed eligible slot wins because later iterations overwrite earlier ones.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    op_i  = '0;
    for (int i = 0; i < NSLOT; i++) begin
      op_i = reg_out_flat[i*INSN_W+82 +: 6];
      if ((op_i == OP_LW || op_i == OP_SW || op_i == OP_LB || op_i == OP_SB) &&
          reg_start_flat[i*3 +: 3] == 3'b010) begin
        found = 1'b1;
        sel   = IDXW'(i);
      end
    end
  end

  assign sel_slot         = reg_out_flat[sel*INSN_W +: INSN_W];
  assign sel_op           = sel_slot[87:82];
  assign sel_imm          = sel_slot[66:51];
  assign reg_search_out10 = sel_slot[81:77];
  assign reg_search_out11 = sel_slot[71:67];
  assign sel_load         = (sel_op == OP_LW) || (sel_op == OP_LB);
  assign sel_byte         = (sel_op == OP_LB) || (sel_op == OP_SB);
  assign addr_calc        = sel_byte ? AW'(reg_out10)
                                     : AW'(reg_out10) + {{(AW-16){sel_imm[15]}}, sel_imm};
  assign sel_mis          = !sel_byte && (addr_calc[1:0] != 2'b00);
  assign be_calc          = sel_byte ? (4'b0001 << addr_calc[1:0]) : 4'b1111;
  assign wdata_calc       = sel_byte ? {4{reg_out11[7:0]}} : reg_out11;
  assign unused_bits      = ^{reg_out_flat, sel_slot};

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = sel_mis ? DONE : REQ;
      REQ:     if (mem_gnt) state_d = load_q ? WAIT : DONE;
      WAIT:    if (mem_rvalid) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  assign rbyte = mem_rdata[addr_q[1:0]*8 +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      load_q   <= 1'b0;
      byte_q   <= 1'b0;
      mis_q    <= 1'b0;
      rd_q     <= '0;
      st_q     <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && found) begin
        idx_q   <= sel;
        load_q  <= sel_load;
        byte_q  <= sel_byte;
        mis_q   <= sel_mis;
        rd_q    <= reg_search_out11;
        st_q    <= reg_start_flat[sel*3 +: 3];
        addr_q  <= addr_calc;
        be_q    <= be_calc;
        wdata_q <= wdata_calc;
      end
      if (state_q == WAIT && mem_rvalid)
        result_q <= byte_q ? {{24{rbyte[7]}}, rbyte} : mem_rdata;
    end
  end

  assign busy            = (state_q != IDLE);
  assign mem_req         = (state_q == REQ);
  assign mem_we          = (state_q == REQ) && !load_q;
  assign mem_addr        = addr_q;
  assign mem_be          = be_q;
  assign mem_wdata       = wdata_q;
  assign err             = (state_q == DONE) && mis_q;
  assign reg_in10_start  = (state_q == DONE) && load_q && !mis_q;
  assign reg_in10        = result_q;
  assign reg_search_in10 = rd_q;
  assign stamp_in        = (state_q == DONE) ? (NSLOT'(1) << idx_q) : '0;

  always_comb begin
    stamp_flat = '0;
    if (state_q == DONE)
      stamp_flat[idx_q*3 +: 3] = mis_q ? 3'b111 : {st_q[2], 1'b1, st_q[0]};
  end
endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter NSLOT, default 8, number of instruction slots scanned.
REQ-002 Parameter INSN_W, default 88, width of one instruction slot.
REQ-003 Parameter AW, default 32, memory address width; data width fixed at 32.
REQ-004 Clock is single, reset is asynchronous active-low: clk in 1, rising-edge clock.
REQ-005 rst_n in 1, asynchronous active-low reset.
REQ-006 reg_start_flat in 3*NSLOT, per-slot status; 3'b010 = ready for memory stage.
REQ-007 reg_out_flat in INSN_W*NSLOT, slot i at [i*INSN_W +: INSN_W].
REQ-008 stamp_flat out 3*NSLOT, new status per slot; stamp_in out NSLOT, one-cycle write strobe per slot.
REQ-009 reg_search_out10 / reg_out10 out 5 / in 32, base-register read port (rs).
REQ-010 reg_search_out11 / reg_out11 out 5 / in 32, store-data read port (rd).
REQ-011 reg_search_in10 out 5, reg_in10 out 32, reg_in10_start out 1, writeback port.
REQ-012 mem_req out 1, mem_we out 1, mem_addr out AW, mem_be out 4, mem_wdata out 32: request bus.
REQ-013 mem_gnt in 1, request accepted; mem_rvalid in 1, mem_rdata in 32, load data return.
REQ-014 busy out 1, high whenever FSM not IDLE; err out 1, one-cycle misalignment pulse.

Function
REQ-015 Slot fields: opcode [87:82], rs [81:77], rd [71:67], imm16 [66:51] sign-extended; status bits [2:0].
REQ-016 Opcodes: 001010 LW, 001011 SW (addr = rs + sext(imm16)); 001100 LB, 001101 SB (addr = rs, offset ignored).
REQ-017 In IDLE, eligible slot = memory opcode AND status 3'b010; highest index wins; one op in flight.
REQ-018 FSM states IDLE, REQ, WAIT, DONE; IDLE->REQ on eligible slot, latching slot index, opcode, rd, address, store data.
REQ-019 rs/rd read ports driven combinationally from highest eligible slot in IDLE; values sampled on IDLE->REQ edge.
REQ-020 REQ: mem_req held high with stable addr/we/be/wdata until mem_gnt; store -> DONE, load -> WAIT, same edge as gnt.
REQ-021 WAIT: on mem_rvalid, capture data -> DONE; rvalid outside WAIT ignored.
REQ-022 LB: mem_be = one-hot of addr[1:0]; result = sign-extended byte addr[1:0] of mem_rdata.
REQ-023 SB: mem_be one-hot of addr[1:0]; mem_wdata = store byte replicated in all four lanes.
REQ-024 LW/SW: mem_be = 4'b1111, full word; addr[1:0] != 0 -> no memory request, err pulse, stamp 3'b111, FSM IDLE->DONE.
REQ-025 DONE (one cycle): loads assert reg_in10_start with rd, data; stamp_in[idx]=1, stamp = {st[2],1,st[0]} from latched status.
REQ-026 DONE->IDLE always; new op may start no earlier than cycle after DONE (min 3 cycles store, 4 load).
REQ-027 Writes to rd=0 still issued; register file owns r0 semantics.
REQ-028 Address arithmetic modulo 2^AW; wrap-around silent.
REQ-029 Slot status changes during REQ/WAIT ignored; latched copy used.

Reset
REQ-030 rst_n low: state IDLE, mem_req, mem_we, reg_in10_start, stamp_in, err, busy all 0; mem_addr, mem_be, mem_wdata, stamp_flat 0.
REQ-031 Reset mid-operation abandons op; no writeback or stamp; first op after release starts from IDLE.

Verification
REQ-032 Slot 7 LB rs=x1000_0002, mem_rdata=0x00800000, gnt cycle 1 -> be=0100, reg_in10=0xFFFFFF80, stamp_in=0x80.
REQ-033 Slots 2 and 5 SB ready -> slot 5 served first, be per addr, wdata=byte x4; slot 2 next after DONE.
REQ-034 LW rs=0x100, imm16=0xFFFC, gnt delayed 3 cycles -> addr 0xFC held stable, mem_req high 4 cycles.
REQ-035 SW rs=0x102 -> no mem_req, err pulse one cycle, stamp 3'b111 for slot.
REQ-036 rst_n low during WAIT, then rvalid -> no reg_in10_start, no stamp_in, busy 0.
REQ-037 rvalid pulse while IDLE -> no output change.
